// File: rtl/mcdt_formatter_if.sv
// mcdt_formatter bus interface: merged mcdt input stream plus the packet output bus.
// The slave modport is the formatter's view and the master modport is the
// upstream/consumer side. FMT_DROP_CNT_EN adds the per-channel drop counter bus.
interface mcdt_formatter_if;
    logic [31:0] mcdt_data_i;
    logic        mcdt_val_i;
    logic [1:0]  mcdt_id_i;
    logic        fmt_req_o;
    logic        fmt_grant_i;
    logic [1:0]  fmt_chid_o;
    logic [31:0] fmt_data_o;
    logic        fmt_start_o;
    logic        fmt_end_o;
    logic [2:0]  fmt_ovf_o;
    logic        fmt_id_err_o;
`ifdef FMT_DROP_CNT_EN
    logic [23:0] fmt_drop_cnt_o;

    modport master (
        output mcdt_data_i, mcdt_val_i, mcdt_id_i, fmt_grant_i,
        input  fmt_req_o, fmt_chid_o, fmt_data_o, fmt_start_o, fmt_end_o,
               fmt_ovf_o, fmt_id_err_o, fmt_drop_cnt_o
    );

    modport slave (
        input  mcdt_data_i, mcdt_val_i, mcdt_id_i, fmt_grant_i,
        output fmt_req_o, fmt_chid_o, fmt_data_o, fmt_start_o, fmt_end_o,
               fmt_ovf_o, fmt_id_err_o, fmt_drop_cnt_o
    );
`else
    modport master (
        output mcdt_data_i, mcdt_val_i, mcdt_id_i, fmt_grant_i,
        input  fmt_req_o, fmt_chid_o, fmt_data_o, fmt_start_o, fmt_end_o,
               fmt_ovf_o, fmt_id_err_o
    );

    modport slave (
        input  mcdt_data_i, mcdt_val_i, mcdt_id_i, fmt_grant_i,
        output fmt_req_o, fmt_chid_o, fmt_data_o, fmt_start_o, fmt_end_o,
               fmt_ovf_o, fmt_id_err_o
    );
`endif
endinterface

// File: rtl/mcdt_formatter.sv
// mcdt_formatter: captures the merged mcdt stream into three per-channel FIFOs and
// emits fixed-length single-channel packets round-robin under a req/grant handshake.
// Writes to a full FIFO are dropped and flagged in a sticky per-channel overflow bit.
// Optional feature macro FMT_DROP_CNT_EN: adds three 8-bit saturating drop counters.
module mcdt_formatter #(
    parameter int DEPTH   = 16,
    parameter int PKT_LEN = 4
) (
    input logic             clk_i,
    input logic             rstn_i,
    mcdt_formatter_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(PKT_LEN + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] PKT_CNT   = CW'(PKT_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
    localparam logic [BW-1:0] DONE_BEAT = BW'(PKT_LEN);

    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

    state_t      state_q, state_d;
    logic [1:0]  chid_q, chid_d;
    logic [1:0]  rr_q, rr_d;
    logic [BW-1:0] beat_q, beat_d;
    logic        req_q, req_d;
    logic        start_q, start_d;
    logic        end_q, end_d;
    logic [31:0] data_q, data_d;
    logic        pop;

    logic [31:0]   mem [3][DEPTH];
    logic [CW-1:0] count_q [3];
    logic [AW-1:0] wr_ptr_q [3];
    logic [AW-1:0] rd_ptr_q [3];

    logic [2:0]  push_sel;
    logic [2:0]  pop_sel;
    logic [2:0]  drop_sel;
    logic        id_bad;
    logic [2:0]  elig;
    logic        any_elig;
    logic [1:0]  pick_ch;
    logic [1:0]  scan_ch;
    logic [31:0] pop_data;
    logic [2:0]  ovf_q;
    logic        id_err_q;

    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    // Decide per channel whether this cycle's write is stored, dropped, or whether a pop happens
    always_comb begin
        push_sel = '0;
        drop_sel = '0;
        pop_sel  = '0;
        id_bad   = bus.mcdt_val_i && (bus.mcdt_id_i == 2'd3);
        for (int c = 0; c < 3; c++) begin
            pop_sel[c] = pop && (chid_q == 2'(c));
            if (bus.mcdt_val_i && (bus.mcdt_id_i == 2'(c))) begin
                if ((count_q[c] != FULL_CNT) || pop_sel[c]) begin
                    push_sel[c] = 1'b1;
                end else begin
                    drop_sel[c] = 1'b1;
                end
            end
        end
    end

    // A channel may request the bus once it holds at least one full packet
    always_comb begin
        elig = '0;
        for (int c = 0; c < 3; c++) begin
            elig[c] = (count_q[c] >= PKT_CNT);
        end
    end

    // Scan from the round-robin pointer upward for the first eligible channel
    always_comb begin
        any_elig = 1'b0;
        pick_ch  = rr_q;
        scan_ch  = rr_q;
        for (int i = 0; i < 3; i++) begin
            if (!any_elig && elig[scan_ch]) begin
                any_elig = 1'b1;
                pick_ch  = scan_ch;
            end
            scan_ch = next_ch(scan_ch);
        end
    end

    // Head-of-FIFO word of the channel currently owning the bus
    always_comb begin
        pop_data = '0;
        for (int c = 0; c < 3; c++) begin
            if (chid_q == 2'(c)) begin
                pop_data = mem[c][rd_ptr_q[c]];
            end
        end
    end

    // FIFO storage is not reset; emptiness is tracked by the counts alone
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < 3; c++) begin
            if (push_sel[c]) begin
                mem[c][wr_ptr_q[c]] <= bus.mcdt_data_i;
            end
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < 3; c++) begin
                count_q[c]  <= '0;
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (push_sel[c]) begin
                    wr_ptr_q[c] <= wr_ptr_q[c] + AW'(1);
                end
                if (pop_sel[c]) begin
                    rd_ptr_q[c] <= rd_ptr_q[c] + AW'(1);
                end
                case ({push_sel[c], pop_sel[c]})
                    2'b10:   count_q[c] <= count_q[c] + CW'(1);
                    2'b01:   count_q[c] <= count_q[c] - CW'(1);
                    default: count_q[c] <= count_q[c];
                endcase
            end
        end
    end

    // Sticky error flags: overflow per channel and illegal channel id
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_q    <= '0;
            id_err_q <= 1'b0;
        end else begin
            ovf_q    <= ovf_q | drop_sel;
            id_err_q <= id_err_q | id_bad;
        end
    end

`ifdef FMT_DROP_CNT_EN
    logic [7:0] drop_cnt_q [3];

    // Saturating per-channel count of dropped writes
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < 3; c++) begin
                drop_cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (drop_sel[c] && (drop_cnt_q[c] != 8'hFF)) begin
                    drop_cnt_q[c] <= drop_cnt_q[c] + 8'd1;
                end
            end
        end
    end

    assign bus.fmt_drop_cnt_o = {drop_cnt_q[2], drop_cnt_q[1], drop_cnt_q[0]};
`endif

    // State register plus the registered packet outputs and bookkeeping
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            chid_q  <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
            req_q   <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            chid_q  <= chid_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            req_q   <= req_d;
            start_q <= start_d;
            end_q   <= end_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic: IDLE picks a channel, REQ waits for grant, SEND streams the packet
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_elig) state_d = REQ;
            REQ:     if (bus.fmt_grant_i) state_d = SEND;
            SEND:    if (beat_q == DONE_BEAT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: beats are loaded into the output registers at the edge that pops them
    always_comb begin
        chid_d  = chid_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        req_d   = 1'b0;
        start_d = 1'b0;
        end_d   = 1'b0;
        data_d  = '0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    chid_d = pick_ch;
                    req_d  = 1'b1;
                end
            end
            REQ: begin
                if (bus.fmt_grant_i) begin
                    pop     = 1'b1;
                    data_d  = pop_data;
                    start_d = 1'b1;
                    beat_d  = BW'(1);
                end else begin
                    req_d = 1'b1;
                end
            end
            SEND: begin
                if (beat_q != DONE_BEAT) begin
                    pop    = 1'b1;
                    data_d = pop_data;
                    end_d  = (beat_q == LAST_BEAT);
                    beat_d = beat_q + BW'(1);
                end else begin
                    beat_d = '0;
                    rr_d   = next_ch(chid_q);
                end
            end
            default: begin
                beat_d = '0;
            end
        endcase
    end

    assign bus.fmt_req_o    = req_q;
    assign bus.fmt_chid_o   = chid_q;
    assign bus.fmt_data_o   = data_q;
    assign bus.fmt_start_o  = start_q;
    assign bus.fmt_end_o    = end_q;
    assign bus.fmt_ovf_o    = ovf_q;
    assign bus.fmt_id_err_o = id_err_q;

endmodule

// File: tb/tb_mcdt_formatter.sv
// Directed self-checking bench for mcdt_formatter (default build, DEPTH=16, PKT_LEN=4).
module tb_mcdt_formatter;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    mcdt_formatter_if bus();

    mcdt_formatter #(.DEPTH(16), .PKT_LEN(4)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] d);
        bus.mcdt_val_i  = 1'b1;
        bus.mcdt_id_i   = ch;
        bus.mcdt_data_i = d;
        tick();
        bus.mcdt_val_i  = 1'b0;
        bus.mcdt_data_i = '0;
        bus.mcdt_id_i   = '0;
    endtask

    task automatic wait_req(input logic [1:0] ch);
        int n = 0;
        while (bus.fmt_req_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_output("req_seen", 32'(bus.fmt_req_o), 32'd1);
        check_output("req_chid", 32'(bus.fmt_chid_o), 32'(ch));
    endtask

    // Called while beat 0 is on the bus; leaves the bench one cycle after the last beat
    task automatic check_beats(input logic [1:0] ch, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            check_output("beat_data", bus.fmt_data_o, base + 32'(i));
            check_output("beat_start", 32'(bus.fmt_start_o), (i == 0) ? 32'd1 : 32'd0);
            check_output("beat_end", 32'(bus.fmt_end_o), (i == 3) ? 32'd1 : 32'd0);
            check_output("beat_req", 32'(bus.fmt_req_o), 32'd0);
            check_output("beat_chid", 32'(bus.fmt_chid_o), 32'(ch));
            if (i < 3) tick();
        end
        tick();
        check_output("post_data", bus.fmt_data_o, 32'd0);
        check_output("post_start", 32'(bus.fmt_start_o), 32'd0);
        check_output("post_end", 32'(bus.fmt_end_o), 32'd0);
    endtask

    task automatic grant_packet(input logic [1:0] ch, input logic [31:0] base);
        wait_req(ch);
        bus.fmt_grant_i = 1'b1;
        tick();
        bus.fmt_grant_i = 1'b0;
        check_beats(ch, base);
    endtask

    initial begin
        bus.mcdt_val_i  = 1'b0;
        bus.mcdt_id_i   = '0;
        bus.mcdt_data_i = '0;
        bus.fmt_grant_i = 1'b0;

        $display("[TB] reset state");
        tick();
        tick();
        check_output("rst_req", 32'(bus.fmt_req_o), 32'd0);
        check_output("rst_data", bus.fmt_data_o, 32'd0);
        check_output("rst_start", 32'(bus.fmt_start_o), 32'd0);
        check_output("rst_end", 32'(bus.fmt_end_o), 32'd0);
        check_output("rst_chid", 32'(bus.fmt_chid_o), 32'd0);
        check_output("rst_ovf", 32'(bus.fmt_ovf_o), 32'd0);
        check_output("rst_id_err", 32'(bus.fmt_id_err_o), 32'd0);
        rstn_i = 1'b1;
        tick();

        $display("[TB] single ch0 packet, grant held high");
        bus.fmt_grant_i = 1'b1;
        for (int i = 0; i < 4; i++) push(2'd0, 32'h00C0_0000 + 32'(i));
        check_output("t1_req_not_yet", 32'(bus.fmt_req_o), 32'd0);
        tick();
        check_output("t1_req_high", 32'(bus.fmt_req_o), 32'd1);
        check_output("t1_chid", 32'(bus.fmt_chid_o), 32'd0);
        tick();
        check_beats(2'd0, 32'h00C0_0000);
        bus.fmt_grant_i = 1'b0;

        $display("[TB] round robin across channels");
        for (int i = 0; i < 4; i++) push(2'd0, 32'h00C0_0100 + 32'(i));
        for (int i = 0; i < 4; i++) push(2'd1, 32'h00C1_0100 + 32'(i));
        for (int i = 0; i < 4; i++) push(2'd2, 32'h00C2_0100 + 32'(i));
        grant_packet(2'd0, 32'h00C0_0100);
        for (int i = 4; i < 8; i++) push(2'd0, 32'h00C0_0100 + 32'(i));
        grant_packet(2'd1, 32'h00C1_0100);
        for (int i = 4; i < 8; i++) push(2'd1, 32'h00C1_0100 + 32'(i));
        grant_packet(2'd2, 32'h00C2_0100);
        grant_packet(2'd0, 32'h00C0_0104);
        grant_packet(2'd1, 32'h00C1_0104);

        $display("[TB] ch1 overflow");
        for (int i = 0; i < 16; i++) push(2'd1, 32'h00C1_0000 + 32'(i));
        check_output("t3_ovf_before", 32'(bus.fmt_ovf_o), 32'd0);
        push(2'd1, 32'h00C1_0010);
        check_output("t3_ovf_after", 32'(bus.fmt_ovf_o), 32'b010);
        for (int k = 0; k < 4; k++) grant_packet(2'd1, 32'h00C1_0000 + 32'(4 * k));
        tick();
        tick();
        tick();
        check_output("t3_drained_req", 32'(bus.fmt_req_o), 32'd0);

        $display("[TB] push into full ch2 on a pop cycle");
        for (int i = 0; i < 16; i++) push(2'd2, 32'h00C2_1000 + 32'(i));
        wait_req(2'd2);
        bus.mcdt_val_i  = 1'b1;
        bus.mcdt_id_i   = 2'd2;
        bus.mcdt_data_i = 32'h00C2_1010;
        bus.fmt_grant_i = 1'b1;
        tick();
        bus.mcdt_val_i  = 1'b0;
        bus.fmt_grant_i = 1'b0;
        check_output("t4_ovf", 32'(bus.fmt_ovf_o), 32'b010);
        check_beats(2'd2, 32'h00C2_1000);
        grant_packet(2'd2, 32'h00C2_1004);
        grant_packet(2'd2, 32'h00C2_1008);
        grant_packet(2'd2, 32'h00C2_100C);
        for (int i = 1; i < 4; i++) push(2'd2, 32'h00C2_1010 + 32'(i));
        grant_packet(2'd2, 32'h00C2_1010);
        check_output("t4_ovf_end", 32'(bus.fmt_ovf_o), 32'b010);

        $display("[TB] illegal channel id");
        check_output("t5_id_err_before", 32'(bus.fmt_id_err_o), 32'd0);
        for (int i = 0; i < 3; i++) push(2'd0, 32'h00C0_0200 + 32'(i));
        push(2'd3, 32'hDEAD_BEEF);
        check_output("t5_id_err", 32'(bus.fmt_id_err_o), 32'd1);
        check_output("t5_ovf", 32'(bus.fmt_ovf_o), 32'b010);
        tick();
        tick();
        check_output("t5_no_req", 32'(bus.fmt_req_o), 32'd0);
        push(2'd0, 32'h00C0_0203);
        grant_packet(2'd0, 32'h00C0_0200);

        $display("[TB] reset during SEND");
        for (int i = 0; i < 3; i++) push(2'd0, 32'h00C0_0300 + 32'(i));
        for (int i = 0; i < 4; i++) push(2'd1, 32'h00C1_0300 + 32'(i));
        wait_req(2'd1);
        bus.fmt_grant_i = 1'b1;
        tick();
        bus.fmt_grant_i = 1'b0;
        check_output("t6_beat0", bus.fmt_data_o, 32'h00C1_0300);
        tick();
        tick();
        check_output("t6_beat2", bus.fmt_data_o, 32'h00C1_0302);
        #2;
        rstn_i = 1'b0;
        #1;
        check_output("t6_async_data", bus.fmt_data_o, 32'd0);
        check_output("t6_async_start", 32'(bus.fmt_start_o), 32'd0);
        check_output("t6_async_end", 32'(bus.fmt_end_o), 32'd0);
        check_output("t6_async_req", 32'(bus.fmt_req_o), 32'd0);
        check_output("t6_async_chid", 32'(bus.fmt_chid_o), 32'd0);
        check_output("t6_async_ovf", 32'(bus.fmt_ovf_o), 32'd0);
        check_output("t6_async_id_err", 32'(bus.fmt_id_err_o), 32'd0);
        tick();
        check_output("t6_held_end", 32'(bus.fmt_end_o), 32'd0);
        rstn_i = 1'b1;
        tick();
        push(2'd0, 32'h00C0_0400);
        for (int i = 0; i < 3; i++) push(2'd1, 32'h00C1_0400 + 32'(i));
        tick();
        tick();
        tick();
        check_output("t6_counts_cleared", 32'(bus.fmt_req_o), 32'd0);
        for (int i = 1; i < 4; i++) push(2'd0, 32'h00C0_0400 + 32'(i));
        grant_packet(2'd0, 32'h00C0_0400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
